// File: rtl/dbg_pkg.sv
// Shared types and helpers for the debug sequencer.
//   dbg_state_t : run/halt/step controller state encoding
//   NOP_*       : opcodes counted as NOPs by the monitor counters
//   is_nop()    : 1 when an instruction word is one of the NOP opcodes
package dbg_pkg;

  typedef enum logic [1:0] {
    RUNNING  = 2'd0,
    HALTED   = 2'd1,
    STEPPING = 2'd2
  } dbg_state_t;

  localparam logic [7:0] NOP_C8 = 8'hC8;
  localparam logic [7:0] NOP_CF = 8'hCF;
  localparam logic [7:0] NOP_D8 = 8'hD8;
  localparam logic [7:0] NOP_DF = 8'hDF;

  function automatic logic is_nop(input logic [7:0] instr);
    return (instr == NOP_C8) || (instr == NOP_CF) ||
           (instr == NOP_D8) || (instr == NOP_DF);
  endfunction

endpackage

// File: rtl/dbg_counter.sv
// Clearable up-counter used for the monitor statistics.
//   clk        : rising-edge clock
//   sync_reset : synchronous active-high reset, q -> 0
//   clr        : synchronous clear, wins over inc
//   inc        : count enable
//   q          : counter value; wraps to 0 when SATURATE=0, sticks at all-ones when SATURATE=1
module dbg_counter #(
  parameter int W        = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         sync_reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;
  logic         w_at_max;

  assign w_at_max = &r_q;
  assign q        = r_q;

  always_ff @(posedge clk) begin
    if (sync_reset || clr) begin
      r_q <= '0;
    end else if (inc) begin
      if (SATURATE && w_at_max) begin
        r_q <= r_q;
      end else begin
        r_q <= r_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_sequencer.sv
// Run/halt/step controller sitting between program memory and the sequencer/decoder.
// It freezes fetch/execute through hold on operator halt, single-step and PC breakpoint,
// and keeps cycle, executed-instruction and NOP counters for the monitor.
//   clk, sync_reset          : clock, synchronous active-high reset
//   pc, next_instr           : current fetch address and the word being fetched
//   dbg_run/halt/step        : 1-cycle operator pulses
//   bp_en, bp_addr           : PC breakpoint
//   clr_cnt                  : clear all counters
//   hold                     : combinational freeze of pc, ir and reg_en
//   halted, bp_hit           : registered status
//   cycle_cnt/instr_cnt      : wrapping counters (all clocks / unheld clocks)
//   nop_cnt                  : saturating count of unheld clocks fetching a NOP
module debug_sequencer
  import dbg_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int NOP_W         = 8,
  parameter bit START_RUNNING = 1'b1
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic [7:0]       pc,
  input  logic [7:0]       next_instr,
  input  logic             dbg_run,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  input  logic             bp_en,
  input  logic [7:0]       bp_addr,
  input  logic             clr_cnt,
  output logic             hold,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [NOP_W-1:0] nop_cnt
);

  localparam dbg_state_t RESET_STATE = START_RUNNING ? RUNNING : HALTED;

  dbg_state_t r_state;
  dbg_state_t w_next_state;
  logic       r_resume_mask;
  logic       w_next_mask;
  logic       r_bp_hit;
  logic       w_next_bp_hit;
  logic       w_bp_match;
  logic       w_hold;

  // The mask suppresses the breakpoint for the first RUNNING cycle after a resume,
  // so the instruction we halted on can actually execute instead of re-trapping.
  assign w_bp_match = bp_en && (pc == bp_addr) && !r_resume_mask;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state       <= RESET_STATE;
      r_resume_mask <= 1'b1;
      r_bp_hit      <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_resume_mask <= w_next_mask;
      r_bp_hit      <= w_next_bp_hit;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_mask   = r_resume_mask;
    w_next_bp_hit = r_bp_hit;
    w_hold        = 1'b0;
    case (r_state)
      RUNNING: begin
        // Halt is combinational in the same cycle: zero skid.
        w_hold      = w_bp_match || dbg_halt;
        w_next_mask = 1'b0;
        if (w_bp_match || dbg_halt) begin
          w_next_state = HALTED;
        end
        if (w_bp_match) begin
          w_next_bp_hit = 1'b1;
        end
      end
      HALTED: begin
        w_hold = 1'b1;
        if (dbg_run) begin
          w_next_state  = RUNNING;
          w_next_mask   = 1'b1;
          w_next_bp_hit = 1'b0;
        end else if (dbg_step) begin
          w_next_state  = STEPPING;
          w_next_mask   = 1'b1;
          w_next_bp_hit = 1'b0;
        end
      end
      STEPPING: begin
        // One unheld cycle, breakpoint and pulses ignored.
        w_next_state = HALTED;
      end
      default: begin
        w_next_state = RESET_STATE;
      end
    endcase
  end

  assign hold   = w_hold;
  assign halted = (r_state == HALTED);
  assign bp_hit = r_bp_hit;

  dbg_counter #(.W(CNT_W), .SATURATE(1'b0)) u_cycle_cnt (
    .clk        (clk),
    .sync_reset (sync_reset),
    .clr        (clr_cnt),
    .inc        (1'b1),
    .q          (cycle_cnt)
  );

  dbg_counter #(.W(CNT_W), .SATURATE(1'b0)) u_instr_cnt (
    .clk        (clk),
    .sync_reset (sync_reset),
    .clr        (clr_cnt),
    .inc        (!w_hold),
    .q          (instr_cnt)
  );

  dbg_counter #(.W(NOP_W), .SATURATE(1'b1)) u_nop_cnt (
    .clk        (clk),
    .sync_reset (sync_reset),
    .clr        (clr_cnt),
    .inc        (!w_hold && is_nop(next_instr)),
    .q          (nop_cnt)
  );

endmodule
